video_sprite_anim_ctrl: RTL and testbench

- Per-frame sprite motion controller and write arbiter in front of the sprite core's Avalon register port.
- On each frame_start it advances the sprite origin by a signed velocity, handles screen edges, and writes x_origin (0x4) then y_origin (0x8) into the sprite core.
- A host Avalon write port shares the same downstream port. The controller snoops host origin writes so the host can reposition the sprite at any time.

---
 rtl/video_sprite_anim_ctrl.sv | 152 +++++++++++++++
 tb/tb_video_sprite_anim_ctrl.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_sprite_anim_ctrl.sv
// Per-frame sprite motion controller and write arbiter for the sprite core register port.
// Define SPRITE_ANIM_BOUNCE_EN for bounce-off-edges; otherwise positions wrap around.
module video_sprite_anim_ctrl #(
  parameter int unsigned SPRITE_RAM_AW = 10,
  parameter int unsigned SPRITE_HSIZE  = 32,
  parameter int unsigned SPRITE_VSIZE  = 32,
  parameter int unsigned H_DISPLAY     = 640,
  parameter int unsigned V_DISPLAY     = 480
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   frame_start,
  input  logic                   cfg_write,
  input  logic [2:0]             cfg_address,
  input  logic [31:0]            cfg_writedata,
  input  logic                   host_write,
  input  logic [SPRITE_RAM_AW:0] host_address,
  input  logic [31:0]            host_writedata,
  output logic                   host_waitrequest,
  output logic                   avm_write,
  output logic [SPRITE_RAM_AW:0] avm_address,
  output logic [31:0]            avm_writedata,
  output logic                   busy
);

  localparam int unsigned AW = SPRITE_RAM_AW + 1;
  localparam logic signed [16:0] XMax = 17'(H_DISPLAY - SPRITE_HSIZE);
  localparam logic signed [16:0] YMax = 17'(V_DISPLAY - SPRITE_VSIZE);
  localparam logic [AW-1:0] AddrX = AW'(32'd4);
  localparam logic [AW-1:0] AddrY = AW'(32'd8);

  typedef enum logic [1:0] {StIdle, StCalc, StWrX, StWrY} state_e;

  state_e            state_q;
  logic              pending_q, busy_q, own_q, enable_q, enable_d;
  logic [AW-1:0]     ctrl_addr_q;
  logic [31:0]       ctrl_data_q;
  logic [15:0]       pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [15:0]       vx_q, vx_d, vy_q, vy_d;
  logic signed [16:0] nx, ny;
  logic [16:0]       fix_x, fix_y;
  logic              host_acc, snoop_x, snoop_y;

  // Returns {velocity_flip, new_position} for one axis.
  function automatic logic [16:0] edge_fix(input logic signed [16:0] n,
                                           input logic signed [16:0] max);
`ifdef SPRITE_ANIM_BOUNCE_EN
    if (n < 17'sd0) return {1'b1, 16'd0};
    if (n > max)    return {1'b1, max[15:0]};
`else
    if (n < 17'sd0) return {1'b0, 16'(n + max + 17'sd1)};
    if (n > max)    return {1'b0, 16'(n - max - 17'sd1)};
`endif
    return {1'b0, n[15:0]};
  endfunction

  assign host_acc = host_write & ~own_q & ~rst;
  assign snoop_x  = host_acc && (host_address == AddrX);
  assign snoop_y  = host_acc && (host_address == AddrY);

  always_comb begin
    pos_x_d  = pos_x_q;
    pos_y_d  = pos_y_q;
    vx_d     = vx_q;
    vy_d     = vy_q;
    enable_d = enable_q;
    nx       = $signed({1'b0, pos_x_q}) + $signed({vx_q[15], vx_q});
    ny       = $signed({1'b0, pos_y_q}) + $signed({vy_q[15], vy_q});
    fix_x    = edge_fix(nx, XMax);
    fix_y    = edge_fix(ny, YMax);
    if (state_q == StCalc) begin
      if (!snoop_x) begin
        pos_x_d = fix_x[15:0];
        if (fix_x[16]) vx_d = -vx_q;
      end
      if (!snoop_y) begin
        pos_y_d = fix_y[15:0];
        if (fix_y[16]) vy_d = -vy_q;
      end
    end
    // A host origin write always overrides the computed step.
    if (snoop_x) pos_x_d = host_writedata[15:0];
    if (snoop_y) pos_y_d = host_writedata[15:0];
    if (cfg_write) begin
      case (cfg_address)
        3'h0:    enable_d = cfg_writedata[0];
        3'h4:    {vy_d, vx_d} = cfg_writedata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      pending_q   <= 1'b0;
      busy_q      <= 1'b0;
      own_q       <= 1'b0;
      ctrl_addr_q <= '0;
      ctrl_data_q <= '0;
      enable_q    <= 1'b0;
      pos_x_q     <= '0;
      pos_y_q     <= '0;
      vx_q        <= '0;
      vy_q        <= '0;
    end else begin
      enable_q <= enable_d;
      pos_x_q  <= pos_x_d;
      pos_y_q  <= pos_y_d;
      vx_q     <= vx_d;
      vy_q     <= vy_d;
      unique case (state_q)
        StIdle: begin
          if (enable_q && (frame_start || pending_q)) begin
            state_q   <= StCalc;
            pending_q <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        StCalc: begin
          state_q     <= StWrX;
          own_q       <= 1'b1;
          ctrl_addr_q <= AddrX;
          ctrl_data_q <= {16'h0, pos_x_d};
          if (frame_start && enable_q) pending_q <= 1'b1;
        end
        StWrX: begin
          state_q     <= StWrY;
          ctrl_addr_q <= AddrY;
          ctrl_data_q <= {16'h0, pos_y_d};
          if (frame_start && enable_q) pending_q <= 1'b1;
        end
        StWrY: begin
          state_q     <= StIdle;
          own_q       <= 1'b0;
          busy_q      <= 1'b0;
          ctrl_addr_q <= '0;
          ctrl_data_q <= '0;
          if (frame_start && enable_q) pending_q <= 1'b1;
        end
      endcase
    end
  end

  // Outputs are forced quiet while reset is asserted, even mid-sequence.
  assign host_waitrequest = own_q & ~rst;
  assign avm_write        = ~rst & (own_q | host_write);
  assign avm_address      = rst ? '0 : (own_q ? ctrl_addr_q : host_address);
  assign avm_writedata    = rst ? '0 : (own_q ? ctrl_data_q : host_writedata);
  assign busy             = busy_q & ~rst;

endmodule

// File: tb/tb_video_sprite_anim_ctrl.sv
// Directed bench for video_sprite_anim_ctrl; expected edge results follow SPRITE_ANIM_BOUNCE_EN.
module tb_video_sprite_anim_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start = 1'b0;
  logic        cfg_write = 1'b0;
  logic [2:0]  cfg_address = '0;
  logic [31:0] cfg_writedata = '0;
  logic        host_write = 1'b0;
  logic [10:0] host_address = '0;
  logic [31:0] host_writedata = '0;
  logic        host_waitrequest, avm_write, busy;
  logic [10:0] avm_address;
  logic [31:0] avm_writedata;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  video_sprite_anim_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .frame_start      (frame_start),
    .cfg_write        (cfg_write),
    .cfg_address      (cfg_address),
    .cfg_writedata    (cfg_writedata),
    .host_write       (host_write),
    .host_address     (host_address),
    .host_writedata   (host_writedata),
    .host_waitrequest (host_waitrequest),
    .avm_write        (avm_write),
    .avm_address      (avm_address),
    .avm_writedata    (avm_writedata),
    .busy             (busy)
  );

  typedef struct {
    int sx; int sy; int vx; int vy; int ex; int ey; int fx; int fy;
  } edge_vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_wr(input logic [2:0] a, input logic [31:0] d);
    cfg_write = 1'b1; cfg_address = a; cfg_writedata = d;
    tick();
    cfg_write = 1'b0; cfg_address = '0; cfg_writedata = '0;
  endtask

  task automatic host_wr(input logic [10:0] a, input logic [31:0] d);
    host_write = 1'b1; host_address = a; host_writedata = d;
    tick();
    host_write = 1'b0; host_address = '0; host_writedata = '0;
  endtask

  // Pulses frame_start and captures the two origin writes of the sequence.
  task automatic run_frame(output int nwr, output logic [31:0] xd, output logic [31:0] yd);
    nwr = 0; xd = 'x; yd = 'x;
    frame_start = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (avm_write) begin
        nwr++;
        if (k == 2 && avm_address == 11'd4) xd = avm_writedata;
        if (k == 3 && avm_address == 11'd8) yd = avm_writedata;
      end
      tick();
      frame_start = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    host_write = 1'b1; host_address = 11'd4; host_writedata = 32'h0000_ffff;
    tick();
    tick();
    @(negedge clk);
    vectors++;
    if (avm_write !== 1'b0) begin
      miscompares++; $display("FAIL reset_avm_write: got %0h need 0", avm_write);
    end
    vectors++;
    if (avm_address !== 11'd0) begin
      miscompares++; $display("FAIL reset_avm_address: got %0h need 0", avm_address);
    end
    vectors++;
    if (avm_writedata !== 32'd0) begin
      miscompares++; $display("FAIL reset_avm_writedata: got %0h need 0", avm_writedata);
    end
    vectors++;
    if (host_waitrequest !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_wait_busy: got %0b%0b need 00", host_waitrequest, busy);
    end
    host_write = 1'b0; host_address = '0; host_writedata = '0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_step();
    logic        exp_busy [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic        exp_wr   [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [10:0] exp_addr [5] = '{11'd0, 11'd0, 11'd4, 11'd8, 11'd0};
    logic [31:0] exp_data [5] = '{32'd0, 32'd0, 32'd3, 32'd2, 32'd0};
    cfg_wr(3'h0, 32'd1);
    cfg_wr(3'h4, 32'h0002_0003);
    frame_start = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      vectors++;
      if (busy !== exp_busy[k] || avm_write !== exp_wr[k] || avm_address !== exp_addr[k] ||
          avm_writedata !== exp_data[k]) begin
        miscompares++;
        $display("FAIL basic_step N+%0d: got busy=%0b wr=%0b a=%0h d=%0h need %0b %0b %0h %0h",
                 k, busy, avm_write, avm_address, avm_writedata,
                 exp_busy[k], exp_wr[k], exp_addr[k], exp_data[k]);
      end
      tick();
      frame_start = 1'b0;
    end
  endtask

  task automatic test_host_stall();
    int stalls = 0;
    frame_start = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k == 2) begin
        host_write = 1'b1; host_address = 11'h20; host_writedata = 32'hdead_beef;
      end
      @(negedge clk);
      if (host_waitrequest) stalls++;
      if (k == 2) begin
        vectors++;
        if (avm_write !== 1'b1 || avm_address !== 11'd4 || avm_writedata !== 32'd6) begin
          miscompares++;
          $display("FAIL stall_wr_x: got %0b %0h %0h need 1 4 6",
                   avm_write, avm_address, avm_writedata);
        end
      end
      if (k == 3) begin
        vectors++;
        if (avm_write !== 1'b1 || avm_address !== 11'd8 || avm_writedata !== 32'd4) begin
          miscompares++;
          $display("FAIL stall_wr_y: got %0b %0h %0h need 1 8 4",
                   avm_write, avm_address, avm_writedata);
        end
      end
      if (k == 4) begin
        vectors++;
        if (host_waitrequest !== 1'b0 || avm_write !== 1'b1 || avm_address !== 11'h20 ||
            avm_writedata !== 32'hdead_beef) begin
          miscompares++;
          $display("FAIL stall_host_release: got wait=%0b %0b %0h %0h need 0 1 20 deadbeef",
                   host_waitrequest, avm_write, avm_address, avm_writedata);
        end
      end
      tick();
      frame_start = 1'b0;
      if (k == 4) begin
        host_write = 1'b0; host_address = '0; host_writedata = '0;
      end
    end
    vectors++;
    if (stalls !== 2) begin
      miscompares++; $display("FAIL stall_cycles: got %0d need 2", stalls);
    end
  endtask

  task automatic test_edges();
    edge_vec_t vecs [7];
    int nwr;
    logic [31:0] xd, yd;
`ifdef SPRITE_ANIM_BOUNCE_EN
    vecs = '{'{605, 4, 5, 0, 608, 4, 603, 4},     '{603, 4, 5, 0, 608, 4, -1, -1},
             '{2, 4, -5, 0, 0, 4, 5, 4},          '{5, 4, -5, 0, 0, 4, -1, -1},
             '{608, 448, 0, 0, 608, 448, -1, -1}, '{10, 446, 0, 4, 10, 448, 10, 444},
             '{10, 2, 0, -3, 10, 0, 10, 3}};
`else
    vecs = '{'{605, 4, 5, 0, 1, 4, 6, 4},         '{603, 4, 5, 0, 608, 4, -1, -1},
             '{2, 4, -5, 0, 606, 4, 601, 4},      '{5, 4, -5, 0, 0, 4, -1, -1},
             '{608, 448, 0, 0, 608, 448, -1, -1}, '{10, 446, 0, 4, 10, 1, 10, 5},
             '{10, 2, 0, -3, 10, 448, 10, 445}};
`endif
    foreach (vecs[i]) begin
      host_wr(11'd4, 32'(vecs[i].sx));
      host_wr(11'd8, 32'(vecs[i].sy));
      cfg_wr(3'h4, {16'(vecs[i].vy), 16'(vecs[i].vx)});
      run_frame(nwr, xd, yd);
      vectors++;
      if (nwr !== 2 || xd !== 32'(vecs[i].ex) || yd !== 32'(vecs[i].ey)) begin
        miscompares++;
        $display("FAIL edge_%0d: got n=%0d x=%0d y=%0d need 2 %0d %0d",
                 i, nwr, xd, yd, vecs[i].ex, vecs[i].ey);
      end
      if (vecs[i].fx >= 0) begin
        run_frame(nwr, xd, yd);
        vectors++;
        if (xd !== 32'(vecs[i].fx) || yd !== 32'(vecs[i].fy)) begin
          miscompares++;
          $display("FAIL edge_follow_%0d: got x=%0d y=%0d need %0d %0d",
                   i, xd, yd, vecs[i].fx, vecs[i].fy);
        end
      end
    end
  endtask

  task automatic test_pending();
    int nwr = 0;
    logic b4, b5;
    logic [31:0] d6, d7;
    host_wr(11'd4, 32'd10);
    host_wr(11'd8, 32'd20);
    cfg_wr(3'h4, 32'h0001_0001);
    b4 = 1'bx; b5 = 1'bx; d6 = 'x; d7 = 'x;
    for (int k = 0; k < 10; k++) begin
      frame_start = (k == 0 || k == 2 || k == 3);
      @(negedge clk);
      if (avm_write) nwr++;
      if (k == 4) b4 = busy;
      if (k == 5) b5 = busy;
      if (k == 6 && avm_address == 11'd4) d6 = avm_writedata;
      if (k == 7 && avm_address == 11'd8) d7 = avm_writedata;
      tick();
    end
    frame_start = 1'b0;
    vectors++;
    if (nwr !== 4) begin
      miscompares++; $display("FAIL pending_writes: got %0d need 4", nwr);
    end
    vectors++;
    if (b4 !== 1'b0 || b5 !== 1'b1) begin
      miscompares++; $display("FAIL pending_restart: got busy N+4=%0b N+5=%0b need 0 1", b4, b5);
    end
    vectors++;
    if (d6 !== 32'd12 || d7 !== 32'd22) begin
      miscompares++; $display("FAIL pending_data: got %0d %0d need 12 22", d6, d7);
    end
  endtask

  task automatic test_snoop_collision();
    host_wr(11'd4, 32'd50);
    host_wr(11'd8, 32'd60);
    cfg_wr(3'h4, 32'h0001_0003);
    frame_start = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k == 1) begin
        host_write = 1'b1; host_address = 11'd4; host_writedata = 32'd100;
      end
      @(negedge clk);
      if (k == 1) begin
        vectors++;
        if (host_waitrequest !== 1'b0 || avm_write !== 1'b1 || avm_writedata !== 32'd100) begin
          miscompares++;
          $display("FAIL snoop_forward: got wait=%0b wr=%0b d=%0d need 0 1 100",
                   host_waitrequest, avm_write, avm_writedata);
        end
      end
      if (k == 2) begin
        vectors++;
        if (avm_address !== 11'd4 || avm_writedata !== 32'd100) begin
          miscompares++;
          $display("FAIL snoop_wr_x: got a=%0h d=%0d need 4 100", avm_address, avm_writedata);
        end
      end
      if (k == 3) begin
        vectors++;
        if (avm_address !== 11'd8 || avm_writedata !== 32'd61) begin
          miscompares++;
          $display("FAIL snoop_wr_y: got a=%0h d=%0d need 8 61", avm_address, avm_writedata);
        end
      end
      tick();
      frame_start = 1'b0;
      if (k == 1) begin
        host_write = 1'b0; host_address = '0; host_writedata = '0;
      end
    end
  endtask

  task automatic test_reset_mid();
    int nwr;
    logic [31:0] xd, yd;
    frame_start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      rst = (k == 2);
      @(negedge clk);
      if (k >= 2) begin
        vectors++;
        if (avm_write !== 1'b0 || busy !== 1'b0 || host_waitrequest !== 1'b0 ||
            avm_address !== 11'd0 || avm_writedata !== 32'd0) begin
          miscompares++;
          $display("FAIL reset_mid N+%0d: got wr=%0b busy=%0b wait=%0b a=%0h d=%0h need all 0",
                   k, avm_write, busy, host_waitrequest, avm_address, avm_writedata);
        end
      end
      tick();
      frame_start = 1'b0;
    end
    rst = 1'b0;
    cfg_wr(3'h0, 32'd1);
    run_frame(nwr, xd, yd);
    vectors++;
    if (nwr !== 2 || xd !== 32'd0 || yd !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_mid_pos: got n=%0d x=%0d y=%0d need 2 0 0", nwr, xd, yd);
    end
  endtask

  task automatic test_disable();
    int nwr;
    int busy_cnt = 0;
    logic [31:0] xd, yd;
    cfg_wr(3'h4, 32'h0001_0001);
    cfg_wr(3'h0, 32'd0);
    run_frame(nwr, xd, yd);
    vectors++;
    if (nwr !== 0) begin
      miscompares++; $display("FAIL disabled_frame: got %0d writes need 0", nwr);
    end
    cfg_wr(3'h0, 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      tick();
    end
    vectors++;
    if (busy_cnt !== 0) begin
      miscompares++; $display("FAIL disabled_no_pending: got %0d busy cycles need 0", busy_cnt);
    end
    nwr = 0;
    frame_start = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k == 1) begin
        cfg_write = 1'b1; cfg_address = 3'h0; cfg_writedata = 32'd0;
      end
      @(negedge clk);
      if (avm_write) nwr++;
      tick();
      frame_start = 1'b0;
      cfg_write = 1'b0;
    end
    vectors++;
    if (nwr !== 2) begin
      miscompares++; $display("FAIL disable_mid_completes: got %0d writes need 2", nwr);
    end
    run_frame(nwr, xd, yd);
    vectors++;
    if (nwr !== 0) begin
      miscompares++; $display("FAIL disable_after: got %0d writes need 0", nwr);
    end
  endtask

  initial begin
    test_reset();
    test_basic_step();
    test_host_stall();
    test_edges();
    test_pending();
    test_snoop_collision();
    test_reset_mid();
    test_disable();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
